onchip_mem_dual_slave: RTL and testbench

//  Parametrised on-chip RAM, next generation of the single-port Avalon memory: DATA_W/DEPTH configurable,
//  two independent Avalon-MM slave ports (s1, s2) arbitrated round-robin onto one synchronous RAM,

---
 rtl/onchip_mem_pkg.sv | 29 ++
 rtl/onchip_mem_array.sv | 34 +++
 rtl/onchip_mem_dual_slave.sv | 142 ++++++++++++++
 tb/tb_onchip_mem_dual_slave.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/onchip_mem_pkg.sv
// Shared definitions for the dual-slave on-chip memory.
// Optional build macro: ONCHIP_MEM_OUTREG_EN adds an output register stage,
// which makes the read latency 2 clken-cycles instead of 1.
package onchip_mem_pkg;

  localparam logic PORT_S1 = 1'b0;
  localparam logic PORT_S2 = 1'b1;

  // Identifies the slave port that owns an access or a pending response.
  typedef enum logic {
    GNT_S1 = PORT_S1,
    GNT_S2 = PORT_S2
  } grant_e;

`ifdef ONCHIP_MEM_OUTREG_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif

  // One slot of the response shift register: a read in flight, the port
  // that issued it, and whether it addressed beyond the implemented depth.
  typedef struct packed {
    logic   vld;
    grant_e port;
    logic   oor;
  } rsp_t;

endpackage

// File: rtl/onchip_mem_array.sv
// Single-port synchronous RAM with byte-lane write enables.
// Written as a plain registered-read array so it maps onto block RAM; the
// INIT_FILE image is attached through the device RAM initialisation attribute.
module onchip_mem_array #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 13,
  parameter int DEPTH     = 7500,
  parameter     INIT_FILE = "on_chip_memory.hex",
  localparam int BE_W     = DATA_W / 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] q
);

  (* ram_init_file = INIT_FILE *) logic [DATA_W-1:0] mem [DEPTH];

  // Enabled access: update selected byte lanes on write, always register the read word.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < BE_W; b++) begin
          if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
      q <= mem[addr];
    end
  end

endmodule

// File: rtl/onchip_mem_dual_slave.sv
// Dual Avalon-MM slave front end sharing one synchronous RAM.
// Round-robin arbiter, response shift register and per-port readdata steering.
// Optional build macro: ONCHIP_MEM_OUTREG_EN (registered readdata, latency 2).
// Handshake: a port request is accepted on the rising edge where
// waitrequest is low; each accepted read yields exactly one readdatavalid
// pulse on the issuing port, in acceptance order.
module onchip_mem_dual_slave
  import onchip_mem_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 13,
  parameter int DEPTH     = 7500,
  parameter     INIT_FILE = "on_chip_memory.hex",
  localparam int BE_W     = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clken,
  input  logic [ADDR_W-1:0] s1_address,
  input  logic [BE_W-1:0]   s1_byteenable,
  input  logic              s1_chipselect,
  input  logic              s1_read,
  input  logic              s1_write,
  input  logic [DATA_W-1:0] s1_writedata,
  output logic              s1_waitrequest,
  output logic [DATA_W-1:0] s1_readdata,
  output logic              s1_readdatavalid,
  input  logic [ADDR_W-1:0] s2_address,
  input  logic [BE_W-1:0]   s2_byteenable,
  input  logic              s2_chipselect,
  input  logic              s2_read,
  input  logic              s2_write,
  input  logic [DATA_W-1:0] s2_writedata,
  output logic              s2_waitrequest,
  output logic [DATA_W-1:0] s2_readdata,
  output logic              s2_readdatavalid
);

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  grant_e            last_grant;
  logic              req1, req2, gnt1, gnt2, acc1, acc2;
  logic              ram_en, ram_we, ram_wr, in_range, rd_acc;
  logic [ADDR_W-1:0] ram_addr;
  logic [BE_W-1:0]   ram_be;
  logic [DATA_W-1:0] ram_wdata, ram_q, rd_data;
  rsp_t              pipe [RD_LAT];
  rsp_t              rsp_out;

  // Arbitration: a lone requester wins; on a tie the port that did not win last time wins.
  // Nothing is accepted while clken is low or reset is asserted.
  always_comb begin
    req1 = s1_chipselect & (s1_read | s1_write);
    req2 = s2_chipselect & (s2_read | s2_write);
    gnt1 = req1;
    gnt2 = req2;
    if (req1 && req2) begin
      gnt1 = (last_grant == GNT_S2);
      gnt2 = (last_grant == GNT_S1);
    end
    acc1 = gnt1 & clken & reset_n;
    acc2 = gnt2 & clken & reset_n;
  end

  assign s1_waitrequest = req1 & ~acc1;
  assign s2_waitrequest = req2 & ~acc2;

  // Steer the accepted port onto the RAM; out-of-range writes are dropped here.
  always_comb begin
    ram_addr  = acc2 ? s2_address    : s1_address;
    ram_be    = acc2 ? s2_byteenable : s1_byteenable;
    ram_wdata = acc2 ? s2_writedata  : s1_writedata;
    ram_wr    = acc2 ? s2_write      : s1_write;
    ram_en    = acc1 | acc2;
    in_range  = ({1'b0, ram_addr} < DEPTH_W);
    ram_we    = ram_en & ram_wr & in_range;
    rd_acc    = ram_en & ~ram_wr;
  end

  // Remember the winner of every accepted access for the next tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_grant <= GNT_S2;
    else if (acc1) last_grant <= GNT_S1;
    else if (acc2) last_grant <= GNT_S2;
  end

  onchip_mem_array #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .INIT_FILE(INIT_FILE)
  ) u_array (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .be   (ram_be),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .q    (ram_q)
  );

  // Response shift register: advances only on clken, flushed by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else if (clken) begin
      pipe[0].vld  <= rd_acc;
      pipe[0].port <= acc2 ? GNT_S2 : GNT_S1;
      pipe[0].oor  <= ~in_range;
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign rsp_out = pipe[RD_LAT-1];

`ifdef ONCHIP_MEM_OUTREG_EN
  logic [DATA_W-1:0] data_r;

  // Extra output stage: capture the RAM word one clken-cycle after the access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) data_r <= '0;
    else if (clken) data_r <= ram_q;
  end

  assign rd_data = data_r;
`else
  assign rd_data = ram_q;
`endif

  // Route the response to its issuing port; out-of-range reads return zero.
  always_comb begin
    s1_readdatavalid = rsp_out.vld & clken & (rsp_out.port == GNT_S1);
    s2_readdatavalid = rsp_out.vld & clken & (rsp_out.port == GNT_S2);
    s1_readdata = '0;
    s2_readdata = '0;
    if (rsp_out.vld && !rsp_out.oor) begin
      if (rsp_out.port == GNT_S1) s1_readdata = rd_data;
      else                        s2_readdata = rd_data;
    end
  end

endmodule

// File: tb/tb_onchip_mem_dual_slave.sv
// Self-checking bench for onchip_mem_dual_slave: directed scenarios plus
// randomized traffic, all compared against a word-array memory model with
// per-port expected-response queues timed in clken-cycles.
module tb_onchip_mem_dual_slave;
  import onchip_mem_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 13;
  localparam int DEPTH  = 7500;
  localparam int BE_W   = DATA_W / 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n, clken;
  always #5 clk = ~clk;

  logic [ADDR_W-1:0] s1_address, s2_address;
  logic [BE_W-1:0]   s1_byteenable, s2_byteenable;
  logic              s1_chipselect, s1_read, s1_write;
  logic              s2_chipselect, s2_read, s2_write;
  logic [DATA_W-1:0] s1_writedata, s2_writedata;
  logic              s1_waitrequest, s2_waitrequest;
  logic [DATA_W-1:0] s1_readdata, s2_readdata;
  logic              s1_readdatavalid, s2_readdatavalid;

  onchip_mem_dual_slave #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .INIT_FILE("")
  ) dut (
    .clk(clk), .reset_n(reset_n), .clken(clken),
    .s1_address(s1_address), .s1_byteenable(s1_byteenable),
    .s1_chipselect(s1_chipselect), .s1_read(s1_read), .s1_write(s1_write),
    .s1_writedata(s1_writedata), .s1_waitrequest(s1_waitrequest),
    .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
    .s2_address(s2_address), .s2_byteenable(s2_byteenable),
    .s2_chipselect(s2_chipselect), .s2_read(s2_read), .s2_write(s2_write),
    .s2_writedata(s2_writedata), .s2_waitrequest(s2_waitrequest),
    .s2_readdata(s2_readdata), .s2_readdatavalid(s2_readdatavalid)
  );

  // ---------------- scoreboard / model ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] exp_q1[$], exp_q2[$];
  int due_q1[$], due_q2[$];
  int ck_cnt   = 0;   // number of rising edges seen with clken high
  int last_win = 2;   // port that won the most recent accepted access

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit req(input int p);
    if (p == 1) return s1_chipselect && (s1_read || s1_write);
    return s2_chipselect && (s2_read || s2_write);
  endfunction

  // Which port (1/2) gets the RAM this cycle, 0 for none.
  function automatic int winner();
    if (!reset_n || !clken) return 0;
    if (req(1) && req(2)) return (last_win == 1) ? 2 : 1;
    if (req(1)) return 1;
    if (req(2)) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    exp_q1.delete(); exp_q2.delete();
    due_q1.delete(); due_q2.delete();
    last_win = 2;
  endtask

  task automatic accept(input int p, input logic [ADDR_W-1:0] a, input logic wr,
                        input logic [BE_W-1:0] be, input logic [DATA_W-1:0] wd);
    logic [DATA_W-1:0] d;
    if (wr) begin
      if (int'(a) < DEPTH)
        for (int b = 0; b < BE_W; b++)
          if (be[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
    end else begin
      d = (int'(a) < DEPTH) ? ref_mem[a] : '0;
      if (p == 1) begin exp_q1.push_back(d); due_q1.push_back(ck_cnt + RD_LAT - 1); end
      else        begin exp_q2.push_back(d); due_q2.push_back(ck_cnt + RD_LAT - 1); end
    end
  endtask

  // Apply what happens on the rising edge just passed.
  task automatic model_edge();
    int w;
    if (!reset_n) begin model_reset(); return; end
    w = winner();
    if (clken) ck_cnt++;
    if (w == 1) accept(1, s1_address, s1_write, s1_byteenable, s1_writedata);
    if (w == 2) accept(2, s2_address, s2_write, s2_byteenable, s2_writedata);
    if (w != 0) last_win = w;
  endtask

  task automatic check_outputs();
    int  w;
    bit  ev;
    w = winner();
    check("s1_waitrequest", s1_waitrequest, req(1) && (w != 1));
    check("s2_waitrequest", s2_waitrequest, req(2) && (w != 2));
    while (due_q1.size() > 0 && due_q1[0] < ck_cnt) begin void'(due_q1.pop_front()); void'(exp_q1.pop_front()); end
    while (due_q2.size() > 0 && due_q2[0] < ck_cnt) begin void'(due_q2.pop_front()); void'(exp_q2.pop_front()); end
    ev = clken && reset_n && due_q1.size() > 0 && due_q1[0] == ck_cnt;
    check("s1_readdatavalid", s1_readdatavalid, ev);
    if (ev) begin
      check("s1_readdata", s1_readdata, exp_q1[0]);
      void'(exp_q1.pop_front()); void'(due_q1.pop_front());
    end
    ev = clken && reset_n && due_q2.size() > 0 && due_q2[0] == ck_cnt;
    check("s2_readdatavalid", s2_readdatavalid, ev);
    if (ev) begin
      check("s2_readdata", s2_readdata, exp_q2[0]);
      void'(exp_q2.pop_front()); void'(due_q2.pop_front());
    end
  endtask

  // One clock: check mid-cycle, model the edge, return 1 time unit after it.
  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_s1(input logic cs, input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                        input logic [BE_W-1:0] be, input logic [DATA_W-1:0] wd);
    s1_chipselect = cs; s1_read = rd; s1_write = wr;
    s1_address = a; s1_byteenable = be; s1_writedata = wd;
  endtask

  task automatic set_s2(input logic cs, input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                        input logic [BE_W-1:0] be, input logic [DATA_W-1:0] wd);
    s2_chipselect = cs; s2_read = rd; s2_write = wr;
    s2_address = a; s2_byteenable = be; s2_writedata = wd;
  endtask

  task automatic idle(input int n);
    set_s1(0, 0, 0, '0, '0, '0);
    set_s2(0, 0, 0, '0, '0, '0);
    repeat (n) step();
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return ADDR_W'(7488 + $urandom_range(0, 11));
      1:       return ADDR_W'($urandom_range(DEPTH, 8191));
      default: return ADDR_W'($urandom_range(0, 63));
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0;
    clken   = 1'b1;
    set_s1(0, 0, 0, '0, '0, '0);
    set_s2(0, 0, 0, '0, '0, '0);
    #1;
    check("reset s1_readdatavalid", s1_readdatavalid, 1'b0);
    check("reset s2_readdatavalid", s2_readdatavalid, 1'b0);
    check("reset s1_readdata", s1_readdata, '0);
    check("reset s2_readdata", s2_readdata, '0);
    repeat (2) step();
    reset_n = 1'b1;

    // Preload the regions that reads will touch.
    for (int a = 0; a < 64; a++) begin
      set_s1(1, 0, 1, ADDR_W'(a), 4'hF, $urandom);
      step();
    end
    set_s1(0, 0, 0, '0, '0, '0);
    for (int a = 7488; a < DEPTH; a++) begin
      set_s2(1, 0, 1, ADDR_W'(a), 4'hF, $urandom);
      step();
    end
    idle(2);

    // Full-word write then read back.
    set_s1(1, 0, 1, 13'h10, 4'hF, 32'hDEADBEEF); step();
    set_s1(1, 1, 0, 13'h10, 4'h0, '0);           step();
    idle(3);

    // Partial write: low two lanes only.
    set_s1(1, 0, 1, 13'h10, 4'h3, 32'h0000A5A5); step();
    set_s1(1, 1, 0, 13'h10, 4'h0, '0);           step();
    idle(3);

    // Both ports read in the same cycles, held for three cycles.
    set_s1(1, 1, 0, 13'h20, 4'h0, '0);
    set_s2(1, 1, 0, 13'h21, 4'h0, '0);
    repeat (3) step();
    idle(3);

    // Beyond the implemented depth: zero read, ignored write.
    set_s1(1, 1, 0, ADDR_W'(DEPTH), 4'h0, '0);         step();
    set_s1(1, 0, 1, ADDR_W'(DEPTH), 4'hF, 32'h12345678); step();
    set_s1(1, 1, 0, 13'h0, 4'h0, '0);                  step();
    idle(3);

    // clken low for three cycles with a read in flight and a blocked request.
    set_s1(1, 1, 0, 13'h10, 4'h0, '0); step();
    clken = 1'b0;
    set_s1(0, 0, 0, '0, '0, '0);
    set_s2(1, 1, 0, 13'h05, 4'h0, '0);
    repeat (3) step();
    clken = 1'b1;
    set_s2(0, 0, 0, '0, '0, '0);
    idle(3);

    // Reset asserted in the middle of back-to-back reads.
    for (int i = 0; i < 3; i++) begin
      set_s1(1, 1, 0, ADDR_W'(8 + i), 4'h0, '0);
      step();
    end
    reset_n = 1'b0;
    #1;
    model_reset();
    check("async s1_readdatavalid", s1_readdatavalid, 1'b0);
    check("async s1_readdata", s1_readdata, '0);
    check("async s2_readdatavalid", s2_readdatavalid, 1'b0);
    check("async s1_waitrequest", s1_waitrequest, 1'b1);
    repeat (2) step();
    reset_n = 1'b1;
    set_s1(1, 1, 0, 13'h30, 4'h0, '0);
    set_s2(1, 1, 0, 13'h31, 4'h0, '0);
    repeat (2) step();
    idle(3);

    // Randomized mixed traffic with occasional clken gaps.
    for (int n = 0; n < 3000; n++) begin
      clken = ($urandom_range(0, 9) != 0);
      set_s1($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), rand_addr(),
             4'($urandom), $urandom);
      set_s2($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), rand_addr(),
             4'($urandom), $urandom);
      step();
    end
    clken = 1'b1;
    idle(4);
    check("pending responses drained", 64'(exp_q1.size() + exp_q2.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
